// File: rtl/fp_arg_bank.sv
// Double-buffered FP argument bank: Avalon-MM shadow registers, atomic commit into an active bank
// presented to the NPU core over valid/ready. Optional transfer-done interrupt under FP_ARG_BANK_IRQ_EN.
module fp_arg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_ARGS = 4,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [DATA_W/8-1:0]          byteenable,
    input  logic [DATA_W-1:0]            writedata,
    output logic [DATA_W-1:0]            readdata,
    output logic                         waitrequest,
    output logic [NUM_ARGS*DATA_W-1:0]   out_args,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         irq
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_ARGS);
    localparam logic [ADDR_W-1:0] CNT_ADDR  = ADDR_W'(NUM_ARGS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         load_active;
    logic [NUM_ARGS*DATA_W-1:0]   shadow;
    logic [NUM_ARGS*DATA_W-1:0]   active;
    logic [CNT_W-1:0]             xfer_cnt;
    logic                         wr_req;
    logic                         wr_en;
    logic                         ctrl_wr;
    logic                         commit;
    logic                         accept;
    logic                         pend;
    logic                         status_irq;
    logic                         status_irq_en;

    assign wr_req      = chipselect && !write_n;
    // Shadow writes stall only while a second set is queued, so that set stays frozen until loaded.
    assign waitrequest = wr_req && (address < CTRL_ADDR) && (state == PEND);
    assign wr_en       = wr_req && !waitrequest;
    assign ctrl_wr     = wr_en && (address == CTRL_ADDR);
    assign commit      = ctrl_wr && writedata[0];

    assign out_valid = (state != IDLE);
    assign pend      = (state == PEND);
    assign accept    = out_valid && out_ready;
    assign out_args  = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_active = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_next  = HOLD;
                    load_active = 1'b1;
                end
            end
            HOLD: begin
                if (accept && commit) begin
                    load_active = 1'b1;
                end else if (accept) begin
                    state_next = IDLE;
                end else if (commit) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                // Further commits here are dropped; the queued set is the frozen shadow bank.
                if (accept) begin
                    state_next  = HOLD;
                    load_active = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ARGS; i++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if ((address == ADDR_W'(i)) && byteenable[b]) begin
                        shadow[i*DATA_W + b*8 +: 8] <= writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
        end else if (load_active) begin
            active <= shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

`ifdef FP_ARG_BANK_IRQ_EN
    logic irq_en;
    logic irq_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en <= writedata[2];
        end
    end

    // A new accept takes priority over a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (accept && irq_en) begin
            irq_flag <= 1'b1;
        end else if (ctrl_wr && writedata[1]) begin
            irq_flag <= 1'b0;
        end
    end

    assign irq           = irq_flag;
    assign status_irq    = irq_flag;
    assign status_irq_en = irq_en;
`else
    assign irq           = 1'b0;
    assign status_irq    = 1'b0;
    assign status_irq_en = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (address == ADDR_W'(i)) begin
                readdata = shadow[i*DATA_W +: DATA_W];
            end
        end
        if (address == CTRL_ADDR) begin
            readdata[3:0] = {status_irq_en, status_irq, pend, out_valid};
        end
        if (address == CNT_ADDR) begin
            readdata = DATA_W'(xfer_cnt);
        end
    end

endmodule

// File: tb/tb_fp_arg_bank.sv
// Randomized scoreboard bench for fp_arg_bank: a two-deep queue of committed argument sets models
// the double buffer; a negedge monitor checks valid, data, irq and pops on every accept.
`timescale 1ns/1ps
module tb_fp_arg_bank;
    localparam int DATA_W   = 32;
    localparam int NUM_ARGS = 4;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 8;
    localparam int W        = NUM_ARGS * DATA_W;
`ifdef FP_ARG_BANK_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [ADDR_W-1:0]   address = '0;
    logic                chipselect = 1'b0;
    logic                write_n = 1'b1;
    logic [DATA_W/8-1:0] byteenable = '0;
    logic [DATA_W-1:0]   writedata = '0;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;
    logic [W-1:0]        out_args;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                irq;

    always #5 clk = ~clk;

    fp_arg_bank #(.DATA_W(DATA_W), .NUM_ARGS(NUM_ARGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata), .waitrequest(waitrequest), .out_args(out_args),
        .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: shadow words, queue of delivered sets (front = what the core sees).
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] ref_shadow [NUM_ARGS];
    int                ref_count = 0;
    bit                ref_irq = 0, ref_irq_en = 0;
    bit                commit_req = 0, clr_req = 0, en_wr = 0, en_val = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pack_shadow();
        logic [W-1:0] v;
        for (int i = 0; i < NUM_ARGS; i++) v[i*DATA_W +: DATA_W] = ref_shadow[i];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input int a);
        if (a < NUM_ARGS) return ref_shadow[a];
        if (a == NUM_ARGS)
            return {28'd0, IRQ_ON && ref_irq_en, IRQ_ON && ref_irq, exp_q.size() == 2, exp_q.size() != 0};
        if (a == NUM_ARGS + 1) return 32'(ref_count);
        return '0;
    endfunction

    always @(negedge clk) begin
        int sz;
        bit acc;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < NUM_ARGS; i++) ref_shadow[i] = '0;
            ref_count = 0; ref_irq = 0; ref_irq_en = 0;
        end else begin
            sz  = exp_q.size();
            acc = (sz != 0) && out_ready;
            chk("out_valid", W'(out_valid), W'(sz != 0));
            chk("irq", W'(irq), W'(ref_irq));
            if (sz != 0) chk("out_args", out_args, exp_q[0]);
            if (acc) begin
                void'(exp_q.pop_front());
                ref_count = (ref_count + 1) % (1 << CNT_W);
            end
            if (commit_req && sz < 2) exp_q.push_back(pack_shadow());
            if (IRQ_ON) begin
                if (acc && ref_irq_en) ref_irq = 1;
                else if (clr_req) ref_irq = 0;
                if (en_wr) ref_irq_en = en_val;
            end
        end
        commit_req = 0; clr_req = 0; en_wr = 0;
    end

    task automatic idle(input bit rdy);
        chipselect = 1'b0; write_n = 1'b1; out_ready = rdy;
        #1 chk("waitrequest_idle", W'(waitrequest), W'(0));
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d, input bit rdy);
        bit stall;
        stall = (a < NUM_ARGS) && (exp_q.size() == 2);
        chipselect = 1'b1; write_n = 1'b0; address = a[ADDR_W-1:0];
        byteenable = be; writedata = d; out_ready = rdy;
        if (!stall && a < NUM_ARGS)
            for (int b = 0; b < 4; b++) if (be[b]) ref_shadow[a][8*b +: 8] = d[8*b +: 8];
        if (a == NUM_ARGS) begin
            commit_req = d[0]; clr_req = d[1]; en_wr = 1; en_val = d[2];
        end
        #1 chk("waitrequest_wr", W'(waitrequest), W'(stall));
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name, input bit rdy);
        chipselect = 1'b1; write_n = 1'b1; address = a[ADDR_W-1:0];
        byteenable = '0; writedata = '0; out_ready = rdy;
        #1 chk(name, W'(readdata), W'(exp));
        chk("waitrequest_rd", W'(waitrequest), W'(0));
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic do_reset(input bit rdy);
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; out_ready = rdy;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) rd(i, 32'h0, "reset_read", 0);
        chk("reset_out_args", out_args, '0);
        chk("reset_out_valid", W'(out_valid), W'(0));

        // First commit into IDLE
        wr(0, 4'hF, 32'h3F80_0000, 0);
        wr(1, 4'hF, 32'h4000_0000, 0);
        wr(2, 4'hF, 32'h4040_0000, 0);
        wr(3, 4'hF, 32'h4080_0000, 0);
        wr(NUM_ARGS, 4'hF, 32'h1, 0);
        chk("hold_args", out_args, 128'h4080_0000_4040_0000_4000_0000_3F80_0000);
        rd(NUM_ARGS, 32'h1, "status_hold", 0);

        // Stage a second set while the first is held
        wr(0, 4'hF, 32'hBF80_0000, 0);
        wr(NUM_ARGS, 4'hF, 32'h1, 0);
        rd(NUM_ARGS, 32'h3, "status_pend", 0);
        wr(1, 4'hF, 32'h1234_5678, 0);
        chk("pend_args_unchanged", out_args[31:0], 128'h3F80_0000);
        idle(1);
        chk("pend_load_arg0", out_args[31:0], 128'hBF80_0000);
        chk("pend_load_valid", W'(out_valid), W'(1));
        rd(NUM_ARGS, 32'h1, "status_after_accept", 0);
        rd(NUM_ARGS + 1, 32'h1, "count_one", 0);

        // Byte-lane write
        wr(1, 4'b0010, 32'hAABB_CCDD, 0);
        rd(1, 32'h4000_CC00, "byte_lane", 0);
        idle(1);

`ifdef FP_ARG_BANK_IRQ_EN
        wr(NUM_ARGS, 4'hF, 32'h4, 0);
        wr(NUM_ARGS, 4'hF, 32'h5, 0);
        idle(1);
        chk("irq_set", W'(irq), W'(1));
        wr(NUM_ARGS, 4'hF, 32'h5, 0);
        wr(NUM_ARGS, 4'hF, 32'h6, 1);
        chk("irq_set_wins", W'(irq), W'(1));
        wr(NUM_ARGS, 4'hF, 32'h2, 0);
        chk("irq_cleared", W'(irq), W'(0));
`endif

        // Counter wrap with the core always ready
        do_reset(1);
        for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
            wr(NUM_ARGS, 4'hF, 32'h1, 1);
            idle(1);
        end
        rd(NUM_ARGS + 1, 32'h3, "count_wrap", 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            int op;
            bit rdy;
            op  = $urandom_range(0, 99);
            rdy = 1'($urandom_range(0, 1));
            if (op < 35) wr($urandom_range(0, 7), 4'($urandom), $urandom, rdy);
            else if (op < 55) wr(NUM_ARGS, 4'hF, $urandom | 32'h1, rdy);
            else if (op < 80) begin
                a = $urandom_range(0, 7);
                rd(a, exp_read(a), "rd_rand", rdy);
            end else idle(rdy);
        end

        // Reset while a second set is pending and the core is ready
        idle(1); idle(1);
        wr(2, 4'hF, 32'hDEAD_BEEF, 0);
        wr(NUM_ARGS, 4'hF, 32'h5, 0);
        wr(NUM_ARGS, 4'hF, 32'h5, 0);
        rd(NUM_ARGS, IRQ_ON ? 32'hB : 32'h3, "status_pend2", 0);
        do_reset(1);
        chk("rst_pend_args", out_args, '0);
        chk("rst_pend_valid", W'(out_valid), W'(0));
        chk("rst_pend_irq", W'(irq), W'(0));
        for (int i = 0; i < 8; i++) rd(i, 32'h0, "rst_pend_read", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
